mux_nx1_reg: RTL

- Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready output handshake.
- Two modes. Manual mode: an external select picks the channel. Scan mode: an internal round-robin pointer visits each channel for DWELL load slots.
- It is the general-purpose successor to the fixed 4x1 combinational mux. It sits between multiple data sources and a single downstream consumer.

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_scan_ctrl.sv | 62 ++++++
 rtl/mux_nx1_reg.sv | 104 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 registered multiplexer.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input
//   clog2()                 : ceiling log2, used to size the select/pointer
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan pointer for mux_nx1_reg.
// The pointer stays on a channel for DWELL load slots and then moves to the
// next channel, wrapping from N-1 to 0. It only advances on load slots.
// Any change of mode restarts the scan at channel 0 with a fresh dwell count.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high reset
//   mode    : 0 = manual (pointer parked at 0), 1 = scan
//   load_en : output register takes a new value this cycle
//   ptr     : current scan channel
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 4,
  parameter int SW    = clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          load_en,
  output logic [SW-1:0] ptr
);

  localparam logic [7:0]    DW_LAST  = 8'(DWELL - 1);
  localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [7:0]    dwell_q, dwell_d;
  logic          mode_q;

  always_comb begin
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    if ((mode != mode_q) || (mode == MODE_MANUAL)) begin
      ptr_d   = '0;
      dwell_d = '0;
    end else if (load_en) begin
      if (dwell_q == DW_LAST) begin
        dwell_d = '0;
        ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 8'd1;
      end
    end
  end

  // mode_q tracks mode even while in reset, so leaving reset is never seen
  // as a mode edge.
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (reset) begin
      ptr_q   <= '0;
      dwell_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mux_nx1_reg.sv
// N-channel, W-bit multiplexer with a registered output and valid/ready
// handshake toward a single consumer.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   mode      : 0 = channel chosen by sel, 1 = round-robin scan
//   sel       : manual channel select (ignored in scan mode)
//   data_in   : channel k at bits [k*W +: W]
//   in_valid  : per-channel valid flags
//   out_data  : registered selected word
//   out_ch    : channel index of out_data
//   out_valid : out_data/out_ch hold an unconsumed word
//   out_ready : consumer takes the word this cycle
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  parameter int SW    = clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic [N*W-1:0] data_in,
  input  logic [N-1:0]  in_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);

  logic          load_en;
  logic [SW-1:0] ptr;
  logic [SW-1:0] chan;
  logic          hit;
  logic [W-1:0]  data_sel;

  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;

  assign load_en = !valid_q || out_ready;
  assign chan    = (mode == MODE_SCAN) ? ptr : sel;

  mux_scan_ctrl #(
    .N     (N),
    .DWELL (DWELL),
    .SW    (SW)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .load_en (load_en),
    .ptr     (ptr)
  );

  // Decoding by compare means a select value >= N matches no channel and
  // therefore reads as not valid.
  always_comb begin
    hit      = 1'b0;
    data_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (chan == SW'(k)) begin
        hit      = in_valid[k];
        data_sel = data_in[k*W +: W];
      end
    end
  end

  // Without a capture the accepted word is retired but data/ch keep
  // their stale contents.
  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (load_en) begin
      if (hit) begin
        data_d  = data_sel;
        ch_d    = chan;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule
